// File: rtl/sram_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sram_ctrl_pkg
// Shared definitions for the 64k x 8 synchronous SRAM burst controller:
// default bus widths, the controller state encoding and the read latency
// of the SRAM-plus-capture pipeline.
// -----------------------------------------------------------------------------
package sram_ctrl_pkg;

    // Default geometry of the team SRAM.
    localparam int SRAM_ADDR_W = 16;
    localparam int SRAM_DATA_W = 8;
    localparam int SRAM_LEN_W  = 8;

    // One cycle inside the SRAM plus one capture register in the controller.
    localparam int RD_LAT = 2;

    // Controller state type. The encodings are fixed so that older tools
    // and waveform decoders that expect plain 2-bit codes keep working.
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_WRITE = 2'd1;
    localparam state_t ST_READ  = 2'd2;
    localparam state_t ST_DRAIN = 2'd3;

endpackage : sram_ctrl_pkg

// File: rtl/sram_burst_ctrl_if.sv
// -----------------------------------------------------------------------------
// sram_burst_ctrl_if
// Bundles the host request/data handshakes and the SRAM pin bus of the burst
// controller.
//   master : controller view (drives req_ready, wdata_ready, rdata*, done,
//            busy and the mem_* pins; receives requests, write data and
//            mem_rdata)
//   slave  : environment view (host plus SRAM), the mirror image of master
// -----------------------------------------------------------------------------
interface sram_burst_ctrl_if
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DATA_W = SRAM_DATA_W,
    parameter int LEN_W  = SRAM_LEN_W
);

    // Host request channel
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;

    // Host write-data channel
    logic              wdata_valid;
    logic              wdata_ready;
    logic [DATA_W-1:0] wdata;

    // Host read-data stream and status
    logic              rdata_valid;
    logic [DATA_W-1:0] rdata;
    logic              done;
    logic              busy;

    // SRAM pins
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  req_valid, req_write, req_addr, req_len,
        input  wdata_valid, wdata,
        input  mem_rdata,
        output req_ready, wdata_ready,
        output rdata_valid, rdata, done, busy,
        output mem_addr, mem_wdata, mem_we, mem_re
    );

    modport slave (
        output req_valid, req_write, req_addr, req_len,
        output wdata_valid, wdata,
        output mem_rdata,
        input  req_ready, wdata_ready,
        input  rdata_valid, rdata, done, busy,
        input  mem_addr, mem_wdata, mem_we, mem_re
    );

endinterface : sram_burst_ctrl_if

// File: rtl/sram_burst_ctrl.sv
// -----------------------------------------------------------------------------
// sram_burst_ctrl
// Initiator-side controller for the 64k x 8 synchronous SRAM. Accepts single
// or burst read/write requests over a valid/ready handshake, drives the SRAM
// pins, and returns read data as a stream two cycles after each mem_re.
// Every request ends with one done pulse.
//
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : synchronous active-low reset; also forces every output low
//            while asserted
//   bus    : sram_burst_ctrl_if.master
//            req_valid/req_ready/req_write/req_addr/req_len  host request
//            wdata_valid/wdata_ready/wdata                   write beats
//            rdata_valid/rdata                               read beats
//            done/busy                                       status
//            mem_addr/mem_wdata/mem_we/mem_re/mem_rdata      SRAM pins
// -----------------------------------------------------------------------------
module sram_burst_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DATA_W = SRAM_DATA_W,
    parameter int LEN_W  = SRAM_LEN_W
)(
    input  logic              clk,
    input  logic              rst_n,
    sram_burst_ctrl_if.master bus
);

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_INC  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0]  LEN_ZERO  = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0]  LEN_DEC   = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    // Index of the pipeline stage whose beat is on mem_rdata this cycle.
    localparam int CAP_STG = RD_LAT - 2;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ADDR_W-1:0] addr_r;
    logic [LEN_W-1:0]  cnt_r;
    logic [RD_LAT-1:0] rd_vld_r;   // beat in flight per pipeline stage
    logic [RD_LAT-1:0] rd_last_r;  // that beat is the last of the burst
    logic [DATA_W-1:0] rdata_r;
    logic              done_r;

    logic              handshake_s;
    logic              beat_s;
    logic              issue_s;
    logic              cnt_zero_s;
    logic              advance_s;
    logic              capture_s;
    logic              capture_last_s;

    // Control strobes derived from registered state and host inputs
    always_comb begin
        handshake_s    = (state_r == ST_IDLE) && bus.req_valid;
        beat_s         = (state_r == ST_WRITE) && bus.wdata_valid;
        issue_s        = (state_r == ST_READ);
        cnt_zero_s     = (cnt_r == LEN_ZERO);
        advance_s      = beat_s || issue_s;
        capture_s      = rd_vld_r[CAP_STG];
        capture_last_s = rd_vld_r[CAP_STG] && rd_last_r[CAP_STG];
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    state_nxt_s = bus.req_write ? ST_WRITE : ST_READ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (beat_s && cnt_zero_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WRITE;
                end
            end
            ST_READ: begin
                if (cnt_zero_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_READ;
                end
            end
            ST_DRAIN: begin
                // Leave as the last beat moves into the output register, so
                // IDLE coincides with its rdata_valid/done cycle and a new
                // request can be taken right there. An empty capture stage
                // cannot occur here but must never trap the FSM.
                if (capture_last_s || !capture_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, burst address/count, read pipeline and done pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            addr_r    <= ADDR_ZERO;
            cnt_r     <= LEN_ZERO;
            rd_vld_r  <= {RD_LAT{1'b0}};
            rd_last_r <= {RD_LAT{1'b0}};
            rdata_r   <= DATA_ZERO;
            done_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;

            if (handshake_s) begin
                addr_r <= bus.req_addr;
                cnt_r  <= bus.req_len;
            end else if (advance_s) begin
                // Address wraps naturally at 2^ADDR_W.
                addr_r <= addr_r + ADDR_INC;
                cnt_r  <= cnt_r - LEN_DEC;
            end

            rd_vld_r  <= {rd_vld_r[RD_LAT-2:0], issue_s};
            rd_last_r <= {rd_last_r[RD_LAT-2:0], issue_s && cnt_zero_s};

            // mem_rdata is only meaningful in a slot that follows a mem_re.
            if (capture_s) begin
                rdata_r <= bus.mem_rdata;
            end

            done_r <= (beat_s && cnt_zero_s) || capture_last_s;
        end
    end

    // Host- and SRAM-facing outputs, all held low while reset is asserted
    always_comb begin
        bus.req_ready   = rst_n && (state_r == ST_IDLE);
        bus.wdata_ready = rst_n && (state_r == ST_WRITE);
        bus.mem_we      = rst_n && (state_r == ST_WRITE) && bus.wdata_valid;
        bus.mem_re      = rst_n && (state_r == ST_READ);
        bus.busy        = rst_n && (state_r != ST_IDLE);
        bus.rdata_valid = rst_n && rd_vld_r[RD_LAT-1];
        bus.done        = rst_n && done_r;
        bus.rdata       = rst_n ? rdata_r : DATA_ZERO;
        bus.mem_addr    = rst_n ? addr_r : ADDR_ZERO;
        bus.mem_wdata   = (rst_n && (state_r == ST_WRITE)) ? bus.wdata : DATA_ZERO;
    end

endmodule : sram_burst_ctrl

// File: tb/tb_sram_burst_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_burst_ctrl
// Self-checking bench for sram_burst_ctrl with a behavioural 64k x 8 SRAM
// responder. Expected read beats go into a scoreboard queue when a read is
// requested and are popped by the monitor as rdata_valid beats appear.
// -----------------------------------------------------------------------------
module tb_sram_burst_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    sram_burst_ctrl_if #(.ADDR_W(16), .DATA_W(8), .LEN_W(8)) bus ();

    sram_burst_ctrl #(.ADDR_W(16), .DATA_W(8), .LEN_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // SRAM responder: registered read, data valid only the cycle after mem_re.
    // Outside that slot it returns a poison pattern standing in for a floating bus.
    logic [7:0] sram [0:65535];
    logic [7:0] sram_q     = 8'h00;
    logic       sram_q_vld = 1'b0;

    always @(posedge clk) begin
        if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
        sram_q_vld <= bus.mem_re;
        if (bus.mem_re) sram_q <= sram[bus.mem_addr];
    end

    assign bus.mem_rdata = sram_q_vld ? sram_q : 8'hEE;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int we_cnt, re_cnt, re_runs, done_cnt, rv_cnt;
    int last_we_cyc, done_cyc, first_re_cyc, first_rv_cyc, last_rv_cyc;
    logic        prev_re = 1'b0;
    logic [15:0] we_addr_q [$];
    logic [15:0] re_addr_q [$];
    logic [7:0]  sb_q [$];
    logic [7:0]  mon_exp;

    task automatic clear_stats();
        we_cnt = 0; re_cnt = 0; re_runs = 0; done_cnt = 0; rv_cnt = 0;
        last_we_cyc = -1; done_cyc = -1; first_re_cyc = -1;
        first_rv_cyc = -1; last_rv_cyc = -1;
        we_addr_q.delete();
        re_addr_q.delete();
        sb_q.delete();
    endtask

    // Monitor: records SRAM pin activity and checks read beats against the scoreboard.
    always @(negedge clk) begin
        cyc++;
        if (bus.mem_we === 1'b1) begin
            we_cnt++;
            last_we_cyc = cyc;
            we_addr_q.push_back(bus.mem_addr);
        end
        if (bus.mem_re === 1'b1) begin
            re_cnt++;
            if (prev_re !== 1'b1) re_runs++;
            if (first_re_cyc < 0) first_re_cyc = cyc;
            re_addr_q.push_back(bus.mem_addr);
        end
        prev_re = bus.mem_re;
        if (bus.done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.rdata_valid === 1'b1) begin
            rv_cnt++;
            last_rv_cyc = cyc;
            if (first_rv_cyc < 0) first_rv_cyc = cyc;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL rdata_extra: got beat %02h, scoreboard empty", bus.rdata);
            end else begin
                mon_exp = sb_q.pop_front();
                if (bus.rdata !== mon_exp) begin
                    errors++;
                    $display("FAIL rdata: got %02h expected %02h", bus.rdata, mon_exp);
                end
            end
        end
    end

    // Issue one request; called and returns at posedge+1 (returns in the first busy cycle).
    task automatic send_req(input logic wr, input logic [15:0] a, input logic [7:0] l);
        int n;
        n = 0;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_len   = l;
        bus.req_valid = 1'b1;
        @(negedge clk);
        while (bus.req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL req_timeout: req_ready never rose, got %b expected 1", bus.req_ready);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    // Offer write beats back to back.
    task automatic write_beats(input logic [7:0] d [$]);
        int n;
        for (int i = 0; i < d.size(); i++) begin
            bus.wdata_valid = 1'b1;
            bus.wdata       = d[i];
            n = 0;
            @(negedge clk);
            while (bus.wdata_ready !== 1'b1 && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (n >= 50) begin
                checks++; errors++;
                $display("FAIL wdata_timeout: wdata_ready got %b expected 1", bus.wdata_ready);
            end
            @(posedge clk); #1;
        end
        bus.wdata_valid = 1'b0;
    endtask

    // Wait (bounded) for the done pulse, then return at posedge+1 after it.
    task automatic wait_done();
        int n;
        n = 0;
        @(negedge clk);
        while (bus.done !== 1'b1 && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (n >= 600) begin
            checks++; errors++;
            $display("FAIL done_timeout: done got %b expected 1", bus.done);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = 16'h0000;
        bus.req_len = 8'h00; bus.wdata_valid = 1'b0; bus.wdata = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b0)   begin errors++; $display("FAIL rst_req_ready: got %b expected 0", bus.req_ready); end
        checks++; if (bus.wdata_ready !== 1'b0) begin errors++; $display("FAIL rst_wdata_ready: got %b expected 0", bus.wdata_ready); end
        checks++; if (bus.mem_we !== 1'b0)      begin errors++; $display("FAIL rst_mem_we: got %b expected 0", bus.mem_we); end
        checks++; if (bus.mem_re !== 1'b0)      begin errors++; $display("FAIL rst_mem_re: got %b expected 0", bus.mem_re); end
        checks++; if (bus.rdata_valid !== 1'b0) begin errors++; $display("FAIL rst_rdata_valid: got %b expected 0", bus.rdata_valid); end
        checks++; if (bus.done !== 1'b0)        begin errors++; $display("FAIL rst_done: got %b expected 0", bus.done); end
        checks++; if (bus.busy !== 1'b0)        begin errors++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.rdata !== 8'h00)      begin errors++; $display("FAIL rst_rdata: got %02h expected 00", bus.rdata); end
        checks++; if (bus.mem_addr !== 16'h0000) begin errors++; $display("FAIL rst_mem_addr: got %04h expected 0000", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 8'h00)  begin errors++; $display("FAIL rst_mem_wdata: got %02h expected 00", bus.mem_wdata); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL idle_req_ready: got %b expected 1", bus.req_ready); end
        checks++; if (bus.busy !== 1'b0)      begin errors++; $display("FAIL idle_busy: got %b expected 0", bus.busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_single_write();
        logic [7:0] dq [$];
        clear_stats();
        dq.push_back(8'hA5);
        send_req(1'b1, 16'h1234, 8'd0);
        write_beats(dq);
        wait_done();
        checks++; if (we_cnt != 1) begin errors++; $display("FAIL sw_we_count: got %0d expected 1", we_cnt); end
        checks++; if (we_addr_q.size() < 1 || we_addr_q[0] !== 16'h1234) begin errors++; $display("FAIL sw_addr: got size %0d expected one write at 1234", we_addr_q.size()); end
        checks++; if (done_cyc != last_we_cyc + 1) begin errors++; $display("FAIL sw_done_timing: got cycle %0d expected %0d", done_cyc, last_we_cyc + 1); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL sw_done_count: got %0d expected 1", done_cnt); end
        checks++; if (sram[16'h1234] !== 8'hA5) begin errors++; $display("FAIL sw_sram: got %02h expected a5", sram[16'h1234]); end
    endtask

    task automatic test_burst_read();
        logic [7:0] dq [$];
        clear_stats();
        for (int i = 0; i < 4; i++) dq.push_back(8'h10 + 8'(i));
        send_req(1'b1, 16'h0100, 8'd3);
        write_beats(dq);
        wait_done();
        checks++; if (we_cnt != 4) begin errors++; $display("FAIL bw_we_count: got %0d expected 4", we_cnt); end
        for (int i = 0; i < 4 && i < we_addr_q.size(); i++) begin
            checks++;
            if (we_addr_q[i] !== 16'h0100 + 16'(i)) begin errors++; $display("FAIL bw_addr[%0d]: got %04h expected %04h", i, we_addr_q[i], 16'h0100 + 16'(i)); end
        end
        clear_stats();
        for (int i = 0; i < 4; i++) sb_q.push_back(8'h10 + 8'(i));
        send_req(1'b0, 16'h0100, 8'd3);
        wait_done();
        checks++; if (re_cnt != 4)  begin errors++; $display("FAIL br_re_count: got %0d expected 4", re_cnt); end
        checks++; if (re_runs != 1) begin errors++; $display("FAIL br_re_gaps: got %0d runs expected 1", re_runs); end
        for (int i = 0; i < 4 && i < re_addr_q.size(); i++) begin
            checks++;
            if (re_addr_q[i] !== 16'h0100 + 16'(i)) begin errors++; $display("FAIL br_addr[%0d]: got %04h expected %04h", i, re_addr_q[i], 16'h0100 + 16'(i)); end
        end
        checks++; if (first_rv_cyc != first_re_cyc + 2) begin errors++; $display("FAIL br_latency: got cycle %0d expected %0d", first_rv_cyc, first_re_cyc + 2); end
        checks++; if (done_cyc != last_rv_cyc) begin errors++; $display("FAIL br_done_timing: got cycle %0d expected %0d", done_cyc, last_rv_cyc); end
        checks++; if (rv_cnt != 4) begin errors++; $display("FAIL br_beats: got %0d expected 4", rv_cnt); end
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL br_missing: got %0d left expected 0", sb_q.size()); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL br_done_count: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_wrap();
        logic [7:0]  dq [$];
        logic [15:0] exp_a [3];
        exp_a[0] = 16'hFFFF; exp_a[1] = 16'h0000; exp_a[2] = 16'h0001;
        clear_stats();
        dq.push_back(8'hC1); dq.push_back(8'hC2); dq.push_back(8'hC3);
        send_req(1'b1, 16'hFFFF, 8'd2);
        write_beats(dq);
        wait_done();
        checks++; if (we_addr_q.size() != 3) begin errors++; $display("FAIL wrap_we_count: got %0d expected 3", we_addr_q.size()); end
        for (int i = 0; i < 3 && i < we_addr_q.size(); i++) begin
            checks++;
            if (we_addr_q[i] !== exp_a[i]) begin errors++; $display("FAIL wrap_waddr[%0d]: got %04h expected %04h", i, we_addr_q[i], exp_a[i]); end
        end
        clear_stats();
        sb_q.push_back(8'hC1); sb_q.push_back(8'hC2); sb_q.push_back(8'hC3);
        send_req(1'b0, 16'hFFFF, 8'd2);
        wait_done();
        for (int i = 0; i < 3 && i < re_addr_q.size(); i++) begin
            checks++;
            if (re_addr_q[i] !== exp_a[i]) begin errors++; $display("FAIL wrap_raddr[%0d]: got %04h expected %04h", i, re_addr_q[i], exp_a[i]); end
        end
        checks++; if (rv_cnt != 3) begin errors++; $display("FAIL wrap_beats: got %0d expected 3", rv_cnt); end
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL wrap_missing: got %0d left expected 0", sb_q.size()); end
    endtask

    task automatic test_write_stall();
        logic [7:0] dq [$];
        int n;
        clear_stats();
        send_req(1'b1, 16'h0200, 8'd3);
        bus.wdata_valid = 1'b1;
        bus.wdata       = 8'h20;
        n = 0;
        @(negedge clk);
        while (bus.wdata_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin checks++; errors++; $display("FAIL stall_timeout: wdata_ready got %b expected 1", bus.wdata_ready); end
        @(posedge clk); #1;
        bus.wdata_valid = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL stall_we[%0d]: got %b expected 0", s, bus.mem_we); end
            checks++; if (bus.mem_addr !== 16'h0201) begin errors++; $display("FAIL stall_addr[%0d]: got %04h expected 0201", s, bus.mem_addr); end
            checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL stall_busy[%0d]: got %b expected 1", s, bus.busy); end
            @(posedge clk); #1;
        end
        dq.push_back(8'h21); dq.push_back(8'h22); dq.push_back(8'h23);
        write_beats(dq);
        wait_done();
        checks++; if (we_cnt != 4) begin errors++; $display("FAIL stall_we_count: got %0d expected 4", we_cnt); end
        for (int i = 0; i < 4 && i < we_addr_q.size(); i++) begin
            checks++;
            if (we_addr_q[i] !== 16'h0200 + 16'(i)) begin errors++; $display("FAIL stall_waddr[%0d]: got %04h expected %04h", i, we_addr_q[i], 16'h0200 + 16'(i)); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL stall_done_count: got %0d expected 1", done_cnt); end
        checks++; if (done_cyc != last_we_cyc + 1) begin errors++; $display("FAIL stall_done_timing: got cycle %0d expected %0d", done_cyc, last_we_cyc + 1); end
        checks++; if (sram[16'h0202] !== 8'h22) begin errors++; $display("FAIL stall_sram: got %02h expected 22", sram[16'h0202]); end
    endtask

    task automatic test_reset_mid_read();
        clear_stats();
        send_req(1'b0, 16'h0100, 8'd7);  // now in the first issue cycle
        @(posedge clk); #1;              // second issue cycle
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.mem_re !== 1'b0)      begin errors++; $display("FAIL mr_mem_re: got %b expected 0", bus.mem_re); end
        checks++; if (bus.rdata_valid !== 1'b0) begin errors++; $display("FAIL mr_rdata_valid: got %b expected 0", bus.rdata_valid); end
        checks++; if (bus.busy !== 1'b0)        begin errors++; $display("FAIL mr_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0)        begin errors++; $display("FAIL mr_done: got %b expected 0", bus.done); end
        checks++; if (bus.req_ready !== 1'b1)   begin errors++; $display("FAIL mr_req_ready: got %b expected 1", bus.req_ready); end
        repeat (6) @(posedge clk);
        #1;
        checks++; if (rv_cnt != 0)   begin errors++; $display("FAIL mr_beats: got %0d expected 0", rv_cnt); end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL mr_done_count: got %0d expected 0", done_cnt); end
    endtask

    task automatic test_back_to_back();
        int   acc;
        logic got_done;
        clear_stats();
        sb_q.push_back(8'h5A); sb_q.push_back(8'hA6);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 16'h0300;
        bus.req_len   = 8'd1;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_first_ready: got %b expected 1", bus.req_ready); end
        @(posedge clk); #1;              // write accepted; read request now pending
        bus.req_write   = 1'b0;
        bus.wdata_valid = 1'b1;
        bus.wdata       = 8'h5A;
        acc = 0;
        got_done = 1'b0;
        for (int k = 0; k < 20 && !got_done; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                got_done = 1'b1;
                checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_in_done: got %b expected 1", bus.req_ready); end
            end else begin
                checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_busy: got %b expected 0", bus.req_ready); end
            end
            if (bus.wdata_ready === 1'b1 && bus.wdata_valid === 1'b1) acc++;
            @(posedge clk); #1;
            if (acc == 1) bus.wdata = 8'hA6;
            else if (acc >= 2) bus.wdata_valid = 1'b0;
        end
        bus.req_valid   = 1'b0;
        bus.wdata_valid = 1'b0;
        checks++; if (!got_done) begin errors++; $display("FAIL b2b_write_done: got none expected 1"); end
        @(negedge clk);
        checks++; if (bus.mem_re !== 1'b1) begin errors++; $display("FAIL b2b_second_accept: mem_re got %b expected 1", bus.mem_re); end
        checks++; if (bus.mem_addr !== 16'h0300) begin errors++; $display("FAIL b2b_second_addr: got %04h expected 0300", bus.mem_addr); end
        wait_done();
        checks++; if (rv_cnt != 2) begin errors++; $display("FAIL b2b_beats: got %0d expected 2", rv_cnt); end
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL b2b_missing: got %0d left expected 0", sb_q.size()); end
        checks++; if (done_cnt != 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", done_cnt); end
    endtask

    initial begin
        clear_stats();
        test_reset();
        test_single_write();
        test_burst_read();
        test_wrap();
        test_write_stall();
        test_reset_mid_read();
        test_back_to_back();
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_sram_burst_ctrl

// File: doc/sram_burst_ctrl.md
Name: sram_burst_ctrl

Overview:
Initiator-side controller for the team's 64k x 8 synchronous SRAM. It accepts single or burst read/write requests from a host (for example, the JTAG data-register logic) over a valid/ready handshake. It drives the SRAM address, data, write-enable and read-enable pins, and accounts for the SRAM's registered one-cycle read latency. Read data returns as a stream; every request ends with a single done pulse.

Parameters:
ADDR_W, 16, SRAM address width; addresses wrap modulo 2^ADDR_W.
DATA_W, 8, SRAM data width.
LEN_W, 8, burst-length field width; a burst is req_len+1 beats (1..256).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  synchronous active-low reset.
req_valid  input  1  host request valid.
req_ready  output  1  controller can accept a request; high only in IDLE.
req_write  input  1  1 = write burst, 0 = read burst.
req_addr  input  ADDR_W  burst start address.
req_len  input  LEN_W  number of beats minus 1.
wdata_valid  input  1  write-data beat valid.
wdata_ready  output  1  controller accepts a write beat.
wdata  input  DATA_W  write-data beat.
rdata_valid  output  1  read-data beat valid; no backpressure.
rdata  output  DATA_W  read-data beat.
done  output  1  one-cycle pulse at burst completion.
busy  output  1  high whenever state is not IDLE.
mem_addr  output  ADDR_W  to SRAM address.
mem_wdata  output  DATA_W  to SRAM data_in.
mem_we  output  1  to SRAM write_enable.
mem_re  output  1  to SRAM read_enable.
mem_rdata  input  DATA_W  from SRAM data_out; valid only in the cycle after a mem_re cycle, Z otherwise.

Behaviour:
- One clock: clk. Reset is synchronous and active-low (rst_n). While rst_n=0, and on the first edge after it:
  - state=IDLE
  - req_ready=0, wdata_ready=0, mem_we=0, mem_re=0
  - rdata_valid=0, done=0, busy=0
  - rdata=0, mem_addr=0, mem_wdata=0
- Reset mid-burst aborts immediately: in-flight read pipeline is discarded, no further rdata_valid, no done.
- States: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - req_ready=1.
  - A handshake (req_valid & req_ready) on edge E latches addr=req_addr and cnt=req_len.
  - Next state is WRITE if req_write=1, else READ.
  - Request fields are ignored when there is no handshake.
- WRITE:
  - wdata_ready=1, mem_addr=addr, mem_wdata=wdata, mem_we = wdata_valid & wdata_ready. These are combinational from registered state.
  - Each accepted beat: addr<=addr+1 (wraps 0xFFFF->0x0000), cnt<=cnt-1.
  - Accepting a beat with cnt==0 -> IDLE, and done=1 in the following cycle.
  - Stalls indefinitely while wdata_valid=0.
- READ:
  - mem_re=1 every cycle, mem_addr=addr; addr and cnt advance as in WRITE.
  - Issuing with cnt==0 -> DRAIN.
  - No gaps: an N-beat read holds mem_re high for exactly N consecutive cycles.
- Read pipeline:
  - A mem_re in cycle N makes mem_rdata valid in cycle N+1.
  - The controller registers it, so rdata/rdata_valid appear in cycle N+2.
  - Total read latency is 2 cycles from mem_re.
  - A 2-stage valid shift register tracks in-flight beats.
- DRAIN:
  - mem_re=0; stay until the pipeline is empty, then -> IDLE.
  - done=1 in the same cycle as the last rdata_valid.
- Ordering: beats are delivered in address order, exactly req_len+1 per burst.
- rdata holds its last value when rdata_valid=0; mem_rdata is never sampled outside a valid slot (Z is never captured).
- No new request is accepted until IDLE; the earliest back-to-back request is accepted in the cycle done is high.

Decomposition:
- Package sram_ctrl_pkg: state enum type (IDLE, WRITE, READ, DRAIN); ADDR_W/DATA_W/LEN_W default constants; read-latency constant RD_LAT=2.
- No sub-module is needed; the read-valid pipeline is a small internal shift register.
- The bench instantiates the existing SRAM model as the responder.

Test Plan:
- Single write: addr=0x1234, len=0, wdata=0xA5 -> one mem_we cycle at 0x1234; done the next cycle; SRAM[0x1234]=0xA5.
- Burst read after burst write:
  - write 0x10..0x13 at 0x0100, len=3;
  - then read same addr/len -> mem_re high 4 consecutive cycles; rdata 0x10,0x11,0x12,0x13 starting 2 cycles after the first mem_re; done with the 0x13 beat.
- Wrap-around: write len=2 at 0xFFFF -> addresses 0xFFFF, 0x0000, 0x0001; readback matches.
- Write stall: wdata_valid low 3 cycles between beats 1 and 2 -> mem_we low those cycles; address holds; no extra beats; done after the final beat.
- Reset mid-read: rst_n=0 during the 2nd issue cycle of a len=7 read -> next cycle mem_re=0, rdata_valid=0, busy=0, no done; req_ready=1 after release.
- Handshake gating: req_valid held high while busy -> req_ready=0 throughout; second request accepted exactly in the done cycle.
